// File: rtl/xu_byp_xer_if.sv
// Bus between the decode/ALU/flush logic and the XER bypass/commit block.
interface xu_byp_xer_if #(
  parameter int THREADS = 2
);
  logic [THREADS-1:0]    dec_byp_ex1_vld;
  logic                  dec_byp_ex1_xer_wr;
  logic [9:0]            alu_byp_ex3_xer;
  logic [THREADS-1:0]    xu_byp_flush;
  logic [9:0]            byp_alu_ex2_xer;
  logic [10*THREADS-1:0] byp_xer_arch;
  logic [THREADS-1:0]    byp_xer_ex5_commit;

  modport master (
    output dec_byp_ex1_vld, dec_byp_ex1_xer_wr, alu_byp_ex3_xer, xu_byp_flush,
    input  byp_alu_ex2_xer, byp_xer_arch, byp_xer_ex5_commit
  );

  modport slave (
    input  dec_byp_ex1_vld, dec_byp_ex1_xer_wr, alu_byp_ex3_xer, xu_byp_flush,
    output byp_alu_ex2_xer, byp_xer_arch, byp_xer_ex5_commit
  );
endinterface

// File: rtl/xu_byp_xer.sv
// Per-thread XER bypass for the ex2 ALU operand and ex5 commit into architected XER.
module xu_byp_xer #(
  parameter int THREADS = 2
) (
  input  logic        clk,
  input  logic        rst,
  xu_byp_xer_if.slave bus
);
  localparam int NS = 4;  // stage index 0..3 = ex2..ex5

  logic [NS-1:0]      vld_q, vld_d, wr_q, wr_d;
  logic [THREADS-1:0] tid_q [NS];
  logic [THREADS-1:0] tid_d [NS];
  logic [9:0]         ex4_data_q, ex4_data_d, ex5_data_q, ex5_data_d;
  logic [9:0]         arch_q [THREADS];
  logic [9:0]         arch_d [THREADS];
  logic [NS-1:0]      kill;
  logic               ex1_kill, commit;
  logic               hit3, hit4, hit5;
  logic [9:0]         arch_sel;

  always_comb begin
    for (int i = 0; i < NS; i++) begin
      kill[i] = |(tid_q[i] & bus.xu_byp_flush);
    end
    ex1_kill = |(bus.dec_byp_ex1_vld & bus.xu_byp_flush);
  end

  always_comb begin
    vld_d[0] = (|bus.dec_byp_ex1_vld) & ~ex1_kill;
    tid_d[0] = bus.dec_byp_ex1_vld;
    wr_d[0]  = bus.dec_byp_ex1_xer_wr;
    for (int i = 1; i < NS; i++) begin
      vld_d[i] = vld_q[i-1] & ~kill[i-1];
      tid_d[i] = tid_q[i-1];
      wr_d[i]  = wr_q[i-1];
    end
    ex4_data_d = bus.alu_byp_ex3_xer;
    ex5_data_d = ex4_data_q;
    commit     = vld_q[3] & wr_q[3] & ~kill[3];
    for (int t = 0; t < THREADS; t++) begin
      arch_d[t] = (commit && tid_q[3][t]) ? ex5_data_q : arch_q[t];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q      <= '0;
      wr_q       <= '0;
      ex4_data_q <= '0;
      ex5_data_q <= '0;
      for (int i = 0; i < NS; i++) tid_q[i] <= '0;
      for (int t = 0; t < THREADS; t++) arch_q[t] <= '0;
    end else begin
      vld_q      <= vld_d;
      wr_q       <= wr_d;
      ex4_data_q <= ex4_data_d;
      ex5_data_q <= ex5_data_d;
      for (int i = 0; i < NS; i++) tid_q[i] <= tid_d[i];
      for (int t = 0; t < THREADS; t++) arch_q[t] <= arch_d[t];
    end
  end

  // A commit suppressed by reset must not be reported either.
  always_comb begin
    bus.byp_xer_ex5_commit = {THREADS{commit & ~rst}} & tid_q[3];
    bus.byp_xer_arch       = '0;
    for (int t = 0; t < THREADS; t++) begin
      bus.byp_xer_arch[10*t +: 10] = arch_q[t];
    end
  end

  // Bypass ignores flush: a flushed source can only feed a flushed reader.
  always_comb begin
    hit3     = vld_q[1] & wr_q[1] & (|(tid_q[1] & tid_q[0]));
    hit4     = vld_q[2] & wr_q[2] & (|(tid_q[2] & tid_q[0]));
    hit5     = vld_q[3] & wr_q[3] & (|(tid_q[3] & tid_q[0]));
    arch_sel = arch_q[0];
    for (int t = 0; t < THREADS; t++) begin
      if (tid_q[0][t]) arch_sel = arch_q[t];
    end
    if (!vld_q[0])  bus.byp_alu_ex2_xer = arch_q[0];
    else if (hit3)  bus.byp_alu_ex2_xer = bus.alu_byp_ex3_xer;
    else if (hit4)  bus.byp_alu_ex2_xer = ex4_data_q;
    else if (hit5)  bus.byp_alu_ex2_xer = ex5_data_q;
    else            bus.byp_alu_ex2_xer = arch_sel;
  end
endmodule
